// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the pong match controller and the rest of the game.
// The controller sits on the slave side; the game logic or a bench drives the master side.
interface pong_match_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               new_frame_i;
  logic               start_i;
  logic               player_goal_i;
  logic               pc_goal_i;
  logic               play_en_o;
  logic               serve_o;
  logic               serve_dir_o;
  logic [SCORE_W-1:0] player_score_o;
  logic [SCORE_W-1:0] pc_score_o;
  logic               game_over_o;
  logic               winner_o;
  logic [2:0]         state_o;

  modport master (
    output new_frame_i, start_i, player_goal_i, pc_goal_i,
    input  play_en_o, serve_o, serve_dir_o, player_score_o, pc_score_o,
           game_over_o, winner_o, state_o
  );

  modport slave (
    input  new_frame_i, start_i, player_goal_i, pc_goal_i,
    output play_en_o, serve_o, serve_dir_o, player_score_o, pc_score_o,
           game_over_o, winner_o, state_o
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Match sequencer for pong: start, serve delay, rally, point pause and game over,
// with score keeping and serve direction toward the player who conceded.
module pong_match_ctrl #(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int PAUSE_FRAMES = 90
) (
  input logic              clk_i,
  input logic              rst_i,
  pong_match_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SERVE_WAIT  = 3'd1,
    PLAY        = 3'd2,
    POINT_PAUSE = 3'd3,
    GAME_OVER   = 3'd4
  } state_t;

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         SERVE_CNT = 8'(SERVE_FRAMES);
  localparam logic [7:0]         PAUSE_CNT = 8'(PAUSE_FRAMES);

  state_t             state_reg, state_next;
  logic               start_prev_reg;
  logic [7:0]         frame_cnt_reg, frame_cnt_next;
  logic               play_en_reg, play_en_next;
  logic               serve_reg, serve_next;
  logic               serve_dir_reg, serve_dir_next;
  logic [SCORE_W-1:0] player_score_reg, player_score_next;
  logic [SCORE_W-1:0] pc_score_reg, pc_score_next;
  logic               winner_reg, winner_next;
  logic               start_evt;
  logic [SCORE_W-1:0] player_inc, pc_inc;
  logic [7:0]         frame_inc;

  assign start_evt  = bus.start_i & ~start_prev_reg;
  assign player_inc = player_score_reg + 1'b1;
  assign pc_inc     = pc_score_reg + 1'b1;
  assign frame_inc  = frame_cnt_reg + 8'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg        <= IDLE;
      start_prev_reg   <= 1'b1;
      frame_cnt_reg    <= '0;
      play_en_reg      <= 1'b0;
      serve_reg        <= 1'b0;
      serve_dir_reg    <= 1'b0;
      player_score_reg <= '0;
      pc_score_reg     <= '0;
      winner_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      start_prev_reg   <= bus.start_i;
      frame_cnt_reg    <= frame_cnt_next;
      play_en_reg      <= play_en_next;
      serve_reg        <= serve_next;
      serve_dir_reg    <= serve_dir_next;
      player_score_reg <= player_score_next;
      pc_score_reg     <= pc_score_next;
      winner_reg       <= winner_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    frame_cnt_next    = frame_cnt_reg;
    serve_next        = 1'b0;
    serve_dir_next    = serve_dir_reg;
    player_score_next = player_score_reg;
    pc_score_next     = pc_score_reg;
    winner_next       = winner_reg;

    case (state_reg)
      IDLE, GAME_OVER: begin
        if (start_evt) begin
          state_next        = SERVE_WAIT;
          serve_next        = 1'b1;
          frame_cnt_next    = '0;
          player_score_next = '0;
          pc_score_next     = '0;
          winner_next       = 1'b0;
        end
      end
      SERVE_WAIT: begin
        if (bus.new_frame_i) begin
          if (frame_inc == SERVE_CNT) begin
            state_next     = PLAY;
            frame_cnt_next = '0;
          end else begin
            frame_cnt_next = frame_inc;
          end
        end
      end
      PLAY: begin
        // Simultaneous goals are ambiguous, so the rally is simply replayed.
        if (bus.player_goal_i && bus.pc_goal_i) begin
          state_next     = SERVE_WAIT;
          serve_next     = 1'b1;
          frame_cnt_next = '0;
        end else if (bus.player_goal_i) begin
          player_score_next = player_inc;
          serve_dir_next    = 1'b1;
          frame_cnt_next    = '0;
          if (player_inc == WIN_VAL) begin
            state_next  = GAME_OVER;
            winner_next = 1'b0;
          end else begin
            state_next = POINT_PAUSE;
          end
        end else if (bus.pc_goal_i) begin
          pc_score_next  = pc_inc;
          serve_dir_next = 1'b0;
          frame_cnt_next = '0;
          if (pc_inc == WIN_VAL) begin
            state_next  = GAME_OVER;
            winner_next = 1'b1;
          end else begin
            state_next = POINT_PAUSE;
          end
        end
      end
      POINT_PAUSE: begin
        if (bus.new_frame_i) begin
          if (frame_inc == PAUSE_CNT) begin
            state_next     = SERVE_WAIT;
            serve_next     = 1'b1;
            frame_cnt_next = '0;
          end else begin
            frame_cnt_next = frame_inc;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered so motion enables on exactly the cycle the state reads PLAY.
  assign play_en_next = (state_next == PLAY);

  assign bus.play_en_o      = play_en_reg;
  assign bus.serve_o        = serve_reg;
  assign bus.serve_dir_o    = serve_dir_reg;
  assign bus.player_score_o = player_score_reg;
  assign bus.pc_score_o     = pc_score_reg;
  assign bus.game_over_o    = (state_reg == GAME_OVER);
  assign bus.winner_o       = winner_reg;
  assign bus.state_o        = state_reg;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl with WIN_SCORE=2, SERVE_FRAMES=2, PAUSE_FRAMES=3.
module tb_pong_match_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       pe;
    logic       sv;
    logic       sd;
    logic [3:0] ps;
    logic [3:0] cs;
    logic       go;
    logic       w;
  } out_t;

  typedef struct packed {
    logic rst;
    logic start;
    logic nf;
    logic pg;
    logic cg;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  out_t sb_q[$];
  vec_t tbl[$];

  pong_match_ctrl_if #(.SCORE_W(4)) bus ();

  pong_match_ctrl #(
    .SCORE_W(4), .WIN_SCORE(2), .SERVE_FRAMES(2), .PAUSE_FRAMES(3)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic s, logic nf, logic pg, logic cg,
                              logic [2:0] st, logic pe, logic sv, logic sd,
                              logic [3:0] ps, logic [3:0] cs, logic go, logic w);
    vec_t v;
    v.rst = r; v.start = s; v.nf = nf; v.pg = pg; v.cg = cg;
    v.exp = '{st: st, pe: pe, sv: sv, sd: sd, ps: ps, cs: cs, go: go, w: w};
    return v;
  endfunction

  // Drive one cycle of inputs, queue the expected post-edge outputs, then check them.
  task automatic step(input vec_t v, input string name);
    out_t got, req;
    @(negedge clk);
    rst = v.rst;
    bus.start_i = v.start;
    bus.new_frame_i = v.nf;
    bus.player_goal_i = v.pg;
    bus.pc_goal_i = v.cg;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    got = '{st: bus.state_o, pe: bus.play_en_o, sv: bus.serve_o, sd: bus.serve_dir_o,
            ps: bus.player_score_o, cs: bus.pc_score_o, go: bus.game_over_o,
            w: bus.winner_o};
    req = sb_q.pop_front();
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got st=%0d pe=%0b sv=%0b sd=%0b ps=%0d cs=%0d go=%0b w=%0b, required st=%0d pe=%0b sv=%0b sd=%0b ps=%0d cs=%0d go=%0b w=%0b",
               name, got.st, got.pe, got.sv, got.sd, got.ps, got.cs, got.go, got.w,
               req.st, req.pe, req.sv, req.sd, req.ps, req.cs, req.go, req.w);
    end else begin
      $display("[TB] %s ok: st=%0d ps=%0d cs=%0d", name, got.st, got.ps, got.cs);
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.new_frame_i = 1'b0;
    bus.player_goal_i = 1'b0;
    bus.pc_goal_i = 1'b0;

    //            rst st nf pg cg | st pe sv sd ps cs go w
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // reset state
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0)); // start -> serve pulse
    tbl.push_back(mk(0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // frame 1, start held
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  2, 1, 0, 0, 0, 0, 0, 0)); // frame 2 -> PLAY
    tbl.push_back(mk(0, 0, 0, 1, 0,  3, 0, 0, 1, 1, 0, 0, 0)); // player scores
    tbl.push_back(mk(0, 0, 1, 0, 0,  3, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  3, 0, 0, 1, 1, 0, 0, 0)); // goal ignored in pause
    tbl.push_back(mk(0, 0, 1, 0, 0,  3, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  1, 0, 1, 1, 1, 0, 0, 0)); // 3rd frame -> serve
    tbl.push_back(mk(0, 0, 1, 0, 0,  1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  2, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1,  1, 0, 1, 1, 1, 0, 0, 0)); // both goals -> replay
    tbl.push_back(mk(0, 0, 1, 0, 0,  1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  2, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1,  3, 0, 0, 0, 1, 1, 0, 0)); // pc scores
    tbl.push_back(mk(0, 0, 1, 0, 0,  3, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  3, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  1, 0, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  1, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  2, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1,  4, 0, 0, 0, 1, 2, 1, 1)); // pc wins
    tbl.push_back(mk(0, 0, 0, 1, 0,  4, 0, 0, 0, 1, 2, 1, 1)); // goals ignored
    tbl.push_back(mk(0, 0, 0, 0, 1,  4, 0, 0, 0, 1, 2, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0)); // restart clears

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Start key held through reset must not start a match.
    step(mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0), "held_rst");
    step(mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0), "held_rel0");
    step(mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0), "held_rel1");
    step(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0), "key_up");
    // Frame pulse on the entry cycle must not count.
    step(mk(0, 1, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0), "press_frame");
    step(mk(0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0), "entry_frame1");
    step(mk(0, 0, 1, 0, 0,  2, 1, 0, 0, 0, 0, 0, 0), "entry_frame2");

    // Reach 1:1 then reset in the middle of the point pause.
    step(mk(0, 0, 0, 1, 0,  3, 0, 0, 1, 1, 0, 0, 0), "p_goal");
    for (int k = 0; k < 2; k++)
      step(mk(0, 0, 1, 0, 0,  3, 0, 0, 1, 1, 0, 0, 0), $sformatf("pause%0d", k));
    step(mk(0, 0, 1, 0, 0,  1, 0, 1, 1, 1, 0, 0, 0), "pause_end");
    step(mk(0, 0, 1, 0, 0,  1, 0, 0, 1, 1, 0, 0, 0), "sw1");
    step(mk(0, 0, 1, 0, 0,  2, 1, 0, 1, 1, 0, 0, 0), "sw2");
    step(mk(0, 0, 0, 0, 1,  3, 0, 0, 0, 1, 1, 0, 0), "c_goal_11");
    step(mk(0, 0, 1, 0, 0,  3, 0, 0, 0, 1, 1, 0, 0), "pause_mid");
    step(mk(1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0), "rst_in_pause");
    step(mk(0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0), "idle_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 SHALL have parameter SCORE_W, 4, score counter width; SHALL hold WIN_SCORE.
REQ-002 SHALL have parameter WIN_SCORE, 7, points needed to win a match; range 1..2**SCORE_W-1.
REQ-003 SHALL have parameter SERVE_FRAMES, 60, frames to wait before the ball is released; range 1..255.
REQ-004 SHALL have parameter PAUSE_FRAMES, 90, frames to freeze after a point; range 1..255.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk_i, input, 1, system clock.
REQ-007 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-008 SHALL have port new_frame_i, input, 1, one-cycle pulse per video frame.
REQ-009 SHALL have port start_i, input, 1, level start key, not debounced here.
REQ-010 SHALL have port player_goal_i, input, 1, ball passed the pc paddle, so the player scores.
REQ-011 SHALL have port pc_goal_i, input, 1, ball passed the player paddle, so the pc scores.
REQ-012 SHALL have port play_en_o, output, 1, enables paddle and ball motion in the game logic.
REQ-013 SHALL have port serve_o, output, 1, one-cycle pulse that recentres the ball.
REQ-014 SHALL have port serve_dir_o, output, 1, initial ball direction: 0 toward player, 1 toward pc.
REQ-015 SHALL have port player_score_o, output, SCORE_W, player points.
REQ-016 SHALL have port pc_score_o, output, SCORE_W, pc points.
REQ-017 SHALL have port game_over_o, output, 1, high while in GAME_OVER.
REQ-018 SHALL have port winner_o, output, 1, match winner: 0 player, 1 pc; valid only while game_over_o is high.
REQ-019 SHALL have port state_o, output, 3, state code for debug and LEDs.

Function
REQ-020 SHALL implement states with these codes: IDLE=0, SERVE_WAIT=1, PLAY=2, POINT_PAUSE=3, GAME_OVER=4.
REQ-021 SHALL detect a start event as a rising edge of start_i, using a registered previous value; the previous value resets to 1, so a key held through reset does not trigger a start.
REQ-022 IDLE or GAME_OVER plus start event: next cycle, clear both scores, clear winner_o, enter SERVE_WAIT and pulse serve_o for exactly one cycle.
REQ-023 SERVE_WAIT: frame counter cleared on entry and incremented on each new_frame_i pulse; on the pulse that makes the count equal SERVE_FRAMES, enter PLAY on the next cycle.
REQ-024 play_en_o SHALL be 1 only in PLAY; it is registered and takes effect on the same cycle state becomes PLAY.
REQ-025 PLAY plus player_goal_i only: player_score_o +1 next cycle, serve_dir_o set to 1 (serve toward the conceding pc).
REQ-026 PLAY plus pc_goal_i only: pc_score_o +1 next cycle, serve_dir_o set to 0.
REQ-027 PLAY plus both goal inputs in the same cycle: no score change, serve_dir_o unchanged, enter SERVE_WAIT and pulse serve_o (replay).
REQ-028 After a single goal: if the incremented score equals WIN_SCORE, enter GAME_OVER with winner_o set to the scorer; otherwise enter POINT_PAUSE. The transition occurs on the same edge as the score update.
REQ-029 POINT_PAUSE: count PAUSE_FRAMES new_frame_i pulses (counter cleared on entry); then enter SERVE_WAIT and pulse serve_o.
REQ-030 Goal inputs SHALL be ignored outside PLAY; start events SHALL be ignored in SERVE_WAIT, PLAY and POINT_PAUSE.
REQ-031 A new_frame_i pulse coinciding with a state entry SHALL NOT count toward the new state's frame total.
REQ-032 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-033 GAME_OVER: game_over_o=1, play_en_o=0, scores held until a start event.

Reset
REQ-034 rst_i high at a clock edge SHALL, from the next cycle, set: state IDLE, scores 0, play_en_o 0, serve_o 0, serve_dir_o 0, game_over_o 0, winner_o 0, frame counter 0, state_o 0; this applies from any state, including mid-pause and mid-play.

Verification
(Bench parameters: WIN_SCORE=2, SERVE_FRAMES=2, PAUSE_FRAMES=3.)
REQ-035 Start from IDLE -> serve_o one cycle; state_o=1; after the 2nd new_frame pulse, state_o=2 and play_en_o=1.
REQ-036 In PLAY, player_goal_i one cycle -> player_score_o=1, serve_dir_o=1, state_o=3; after 3 frames, serve_o pulses and state_o=1.
REQ-037 Two pc goals -> pc_score_o=2, state_o=4, game_over_o=1, winner_o=1, play_en_o=0; a further goal pulse leaves scores unchanged.
REQ-038 Both goals in the same cycle at score 1:0 -> scores stay 1:0, serve_o pulses, state_o=1.
REQ-039 start_i held high through reset release -> remains IDLE; release then press -> SERVE_WAIT.
REQ-040 rst_i asserted in POINT_PAUSE at score 1:1 -> next cycle all outputs 0 and state_o=0.
